// File: rtl/acum_secuenciador_pkg.sv
`default_nettype none
// ============================================================================
// acum_secuenciador_pkg : shared types and constants for the accumulator sequencer
// Revision: 1.0
// ============================================================================
package acum_secuenciador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         DRAIN_CYCLES     = 2;
    localparam int         DRAIN_CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [1:0] SEL_IDLE_DEFAULT = 2'b00;

    typedef struct packed {
        logic [2:0] data1;
        logic [2:0] data2;
        logic [1:0] sel;
        logic       last;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/acum_secuenciador_contador.sv
`default_nettype none
// ============================================================================
// contador_sat : CNT_W-bit up counter that sticks at all-ones, sync clear/enable
// Revision: 1.0
// ============================================================================
module contador_sat #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/acum_secuenciador.sv
`default_nettype none
// ============================================================================
// acum_secuenciador : command-driven sequencer for the selective-adder accumulator
// Optional ACUM_SEC_ABORT_EN: a sampled overflow ends the job early.
// Revision: 1.0
// ============================================================================
module acum_secuenciador
    import acum_secuenciador_pkg::*;
#(
    parameter logic [1:0] SEL_IDLE = SEL_IDLE_DEFAULT,
    parameter int         CNT_W    = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_data1,
    input  logic [2:0]       i_cmd_data2,
    input  logic [1:0]       i_cmd_sel,
    input  logic             i_cmd_last,
    output logic [2:0]       o_dp_data1,
    output logic [2:0]       o_dp_data2,
    output logic [1:0]       o_dp_sel,
    output logic             o_dp_rst_n,
    input  logic [5:0]       i_dp_data,
    input  logic             i_dp_overflow,
    output logic             o_busy,
    output logic             o_done,
    output logic [5:0]       o_result,
    output logic             o_err_ovf,
    output logic [CNT_W-1:0] o_op_count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   first_run_q, first_run_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [2:0]             dp_data1_q, dp_data1_d;
    logic [2:0]             dp_data2_q, dp_data2_d;
    logic [1:0]             dp_sel_q, dp_sel_d;
    logic                   dp_rst_n_q, dp_rst_n_d;
    logic [5:0]             result_q, result_d;
    logic                   err_ovf_q, err_ovf_d;

    cmd_t cmd_in;
    logic cmd_ready;
    logic accept;
    logic ovf_hit;
    logic abort;
    logic drive;
    logic capture;

    assign cmd_in = {i_cmd_data1, i_cmd_data2, i_cmd_sel, i_cmd_last};

    always_comb begin
        cmd_ready   = (state_q == ST_RUN);
        accept      = i_cmd_valid && cmd_ready;
        // The first RUN cycle still shows the flag left over from the clear.
        ovf_hit     = i_dp_overflow &&
                      (((state_q == ST_RUN) && !first_run_q) || (state_q == ST_DRAIN));
`ifdef ACUM_SEC_ABORT_EN
        abort       = ovf_hit;
`else
        abort       = 1'b0;
`endif
        state_d     = state_q;
        first_run_d = 1'b0;
        drain_cnt_d = drain_cnt_q;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d     = ST_RUN;
                first_run_d = 1'b1;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (accept && cmd_in.last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (abort || (drain_cnt_q == DRAIN_LAST)) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drive      = accept && !abort;
        dp_data1_d = drive ? cmd_in.data1 : 3'd0;
        dp_data2_d = drive ? cmd_in.data2 : 3'd0;
        dp_sel_d   = drive ? cmd_in.sel   : SEL_IDLE;
        dp_rst_n_d = (state_d != ST_CLEAR);
        result_d   = capture ? i_dp_data : result_q;
        err_ovf_d  = (state_q == ST_CLEAR) ? 1'b0 : (err_ovf_q || ovf_hit);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            first_run_q <= 1'b0;
            drain_cnt_q <= '0;
            dp_data1_q  <= 3'd0;
            dp_data2_q  <= 3'd0;
            dp_sel_q    <= SEL_IDLE;
            dp_rst_n_q  <= 1'b0;
            result_q    <= 6'd0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_run_q <= first_run_d;
            drain_cnt_q <= drain_cnt_d;
            dp_data1_q  <= dp_data1_d;
            dp_data2_q  <= dp_data2_d;
            dp_sel_q    <= dp_sel_d;
            dp_rst_n_q  <= dp_rst_n_d;
            result_q    <= result_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    contador_sat #(
        .CNT_W (CNT_W)
    ) u_op_count (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_clr   (state_q == ST_CLEAR),
        .i_en    (accept),
        .o_count (o_op_count)
    );

    assign o_cmd_ready = cmd_ready;
    assign o_dp_data1  = dp_data1_q;
    assign o_dp_data2  = dp_data2_q;
    assign o_dp_sel    = dp_sel_q;
    assign o_dp_rst_n  = dp_rst_n_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_result    = result_q;
    assign o_err_ovf   = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_acum_secuenciador.sv
`default_nettype none
// ============================================================================
// tb_acum_secuenciador : scoreboard bench with a behavioural accumulator datapath
// Revision: 1.0
// ============================================================================
module tb_acum_secuenciador;
    import acum_secuenciador_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             i_rst, i_start, i_cmd_valid, o_cmd_ready;
    logic [2:0]       i_cmd_data1, i_cmd_data2, o_dp_data1, o_dp_data2;
    logic [1:0]       i_cmd_sel, o_dp_sel;
    logic             i_cmd_last, o_dp_rst_n, i_dp_overflow;
    logic [5:0]       i_dp_data, o_result;
    logic             o_busy, o_done, o_err_ovf;
    logic [CNT_W-1:0] o_op_count;

    always #5 clk = ~clk;

    acum_secuenciador #(.SEL_IDLE(SEL_IDLE_DEFAULT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_data1   (i_cmd_data1),
        .i_cmd_data2   (i_cmd_data2),
        .i_cmd_sel     (i_cmd_sel),
        .i_cmd_last    (i_cmd_last),
        .o_dp_data1    (o_dp_data1),
        .o_dp_data2    (o_dp_data2),
        .o_dp_sel      (o_dp_sel),
        .o_dp_rst_n    (o_dp_rst_n),
        .i_dp_data     (i_dp_data),
        .i_dp_overflow (i_dp_overflow),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_err_ovf     (o_err_ovf),
        .o_op_count    (o_op_count)
    );

    // Behavioural datapath: sel 00 xor, 01 sum, 10 data1, 11 data2; 6-bit wrap with carry flag.
    function automatic logic [5:0] contrib(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return {3'b000, a ^ b};
            2'b01:   return {3'b000, a} + {3'b000, b};
            2'b10:   return {3'b000, a};
            default: return {3'b000, b};
        endcase
    endfunction

    logic [5:0] m_acc;
    logic       m_ovf;
    logic       force_ovf = 1'b0;

    always @(posedge clk) begin
        if (!o_dp_rst_n) begin
            m_acc <= 6'd0;
            m_ovf <= 1'b0;
        end else begin
            {m_ovf, m_acc} <= {1'b0, m_acc} + {1'b0, contrib(o_dp_data1, o_dp_data2, o_dp_sel)};
        end
    end
    assign i_dp_data     = m_acc;
    assign i_dp_overflow = m_ovf | force_ovf;

    typedef struct {
        logic [5:0]       res;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_done;
    cmd_t job_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   cyc    = 0;
    bit   mon_dp = 1'b0;
    int   s_edge, first_acc, last_acc, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse pops one expected job result.
    always @(posedge clk) begin
        #1;
        if (o_done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(o_done), 32'(0));
            end else begin
                e_done = exp_q.pop_front();
                check("result", 32'(o_result), 32'(e_done.res));
                check("op_count", 32'(o_op_count), 32'(e_done.cnt));
                check("err_ovf", 32'(o_err_ovf), 32'(e_done.err));
            end
        end
    end

    // Datapath drive monitor: an accepted command appears for one cycle, otherwise idle values.
    always @(posedge clk) begin : dp_mon
        logic       acc;
        logic [2:0] e1, e2;
        logic [1:0] es;
        if (mon_dp) begin
            acc = i_cmd_valid & o_cmd_ready;
            e1  = acc ? i_cmd_data1 : 3'd0;
            e2  = acc ? i_cmd_data2 : 3'd0;
            es  = acc ? i_cmd_sel   : SEL_IDLE_DEFAULT;
            #1;
            check("dp_data1", 32'(o_dp_data1), 32'(e1));
            check("dp_data2", 32'(o_dp_data2), 32'(e2));
            check("dp_sel", 32'(o_dp_sel), 32'(es));
        end
    end

    function automatic logic [5:0] job_sum();
        logic [5:0] s = 6'd0;
        foreach (job_q[i]) s = s + contrib(job_q[i].data1, job_q[i].data2, job_q[i].sel);
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] job_cnt();
        return (job_q.size() > (2**CNT_W - 1)) ? {CNT_W{1'b1}} : CNT_W'(job_q.size());
    endfunction

    task automatic add_cmd(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s, input logic l);
        cmd_t c;
        c.data1 = a; c.data2 = b; c.sel = s; c.last = l;
        job_q.push_back(c);
    endtask

    task automatic push_exp(input logic [5:0] r, input logic [CNT_W-1:0] c, input logic er);
        exp_t e;
        e.res = r; e.cnt = c; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input int gap, input int ovf_idx, input bit poke_start);
        int budget;
        bit stop;
        stop      = 1'b0;
        first_acc = -1;
        last_acc  = -1;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        s_edge    = cyc;
        for (int i = 0; i < job_q.size(); i++) begin
            i_cmd_data1 = job_q[i].data1;
            i_cmd_data2 = job_q[i].data2;
            i_cmd_sel   = job_q[i].sel;
            i_cmd_last  = job_q[i].last;
            i_cmd_valid = 1'b1;
            if (poke_start && i == 1) i_start = 1'b1;
            budget = 20;
            while (!o_cmd_ready && !o_done && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) begin
                check("ready_timeout", 32'(0), 32'(1));
                stop = 1'b1;
            end else if (o_done) begin
                stop = 1'b1;
            end
            if (stop) break;
            tick();
            i_start = 1'b0;
            if (i == 0) first_acc = cyc;
            last_acc  = cyc;
            force_ovf = (i == ovf_idx);
            if (gap > 0 && i != job_q.size() - 1) begin
                i_cmd_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        i_cmd_valid = 1'b0;
        i_cmd_last  = 1'b0;
        i_start     = 1'b0;
        force_ovf   = 1'b0;
        budget = 20;
        while (!o_done && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("done_timeout", 32'(0), 32'(1));
        done_cyc = cyc;
        i_start  = poke_start;
        tick();
        i_start  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_cmd_valid = 1'b0;
        i_cmd_data1 = 3'd0; i_cmd_data2 = 3'd0; i_cmd_sel = 2'b00; i_cmd_last = 1'b0;
        repeat (3) tick();
        check("rst_dp_rst_n", 32'(o_dp_rst_n), 32'(0));
        check("rst_dp_sel", 32'(o_dp_sel), 32'(SEL_IDLE_DEFAULT));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_done", 32'(o_done), 32'(0));
        check("rst_result", 32'(o_result), 32'(0));
        i_rst = 1'b0;
        tick();
        check("rel_dp_rst_n", 32'(o_dp_rst_n), 32'(1));
        repeat (4) tick();
        check("idle_busy", 32'(o_busy), 32'(0));
        check("idle_ready", 32'(o_cmd_ready), 32'(0));
        check("idle_count", 32'(o_op_count), 32'(0));

        // Commands offered in IDLE are never accepted.
        i_cmd_valid = 1'b1; i_cmd_data1 = 3'd7; i_cmd_data2 = 3'd7; i_cmd_sel = 2'b01; i_cmd_last = 1'b1;
        repeat (3) begin
            check("idle_cmd_ready", 32'(o_cmd_ready), 32'(0));
            tick();
        end
        i_cmd_valid = 1'b0; i_cmd_last = 1'b0;
        check("idle_cmd_count", 32'(o_op_count), 32'(0));

        // Back-to-back three-command job.
        job_q = {};
        add_cmd(3'd1, 3'd2, 2'b01, 1'b0);
        add_cmd(3'd3, 3'd3, 2'b01, 1'b0);
        add_cmd(3'd2, 3'd1, 2'b01, 1'b1);
        push_exp(job_sum(), job_cnt(), 1'b0);
        mon_dp = 1'b1;
        run_job(0, -1, 1'b0);
        check("first_accept_edge", 32'(first_acc - s_edge), 32'(2));
        check("last_accept_edge", 32'(last_acc - s_edge), 32'(4));
        check("done_cycle", 32'(done_cyc + 1 - s_edge), 32'(7));
        check("post_job_busy", 32'(o_busy), 32'(0));

        // Same job with two idle cycles between commands.
        push_exp(job_sum(), job_cnt(), 1'b0);
        run_job(2, -1, 1'b0);
        mon_dp = 1'b0;

        // Six-command job with overflow forced in the third RUN cycle.
        job_q = {};
        for (int i = 0; i < 6; i++) add_cmd(3'd1, 3'd1, 2'b01, (i == 5));
`ifdef ACUM_SEC_ABORT_EN
        push_exp(contrib(3'd1, 3'd1, 2'b01), CNT_W'(3), 1'b1);
`else
        push_exp(job_sum(), job_cnt(), 1'b1);
`endif
        run_job(0, 1, 1'b0);

        // Twenty commands saturate the counter; i_start pokes in RUN and DONE are ignored.
        job_q = {};
        for (int i = 0; i < 20; i++) add_cmd(3'd1, 3'd0, 2'b10, (i == 19));
        push_exp(job_sum(), job_cnt(), 1'b0);
        run_job(0, -1, 1'b1);
        check("start_in_done_ignored", 32'(o_busy), 32'(0));

        // Reset in the middle of RUN.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_data1 = 3'd1; i_cmd_data2 = 3'd1; i_cmd_sel = 2'b01; i_cmd_last = 1'b0;
        tick();
        tick();
`ifndef ACUM_SEC_ABORT_EN
        force_ovf = 1'b1;
        tick();
        force_ovf = 1'b0;
        check("midjob_err_set", 32'(o_err_ovf), 32'(1));
`endif
        check("midjob_busy", 32'(o_busy), 32'(1));
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        tick();
        check("rst_run_busy", 32'(o_busy), 32'(0));
        check("rst_run_done", 32'(o_done), 32'(0));
        check("rst_run_err", 32'(o_err_ovf), 32'(0));
        check("rst_run_count", 32'(o_op_count), 32'(0));
        check("rst_run_dp_rst_n", 32'(o_dp_rst_n), 32'(0));
        i_rst = 1'b0;
        tick();
        check("rst_run_rel_dp_rst_n", 32'(o_dp_rst_n), 32'(1));

        // Fresh job after the reset.
        job_q = {};
        add_cmd(3'd3, 3'd1, 2'b10, 1'b0);
        add_cmd(3'd0, 3'd5, 2'b11, 1'b1);
        push_exp(job_sum(), job_cnt(), 1'b0);
        run_job(0, -1, 1'b0);

        repeat (3) tick();
        check("done_pulses", 32'(n_done), 32'(5));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
